debounce_fsm: RTL and testbench

Tick-driven switch/button debouncer that sits directly downstream of the periodic pulse generator. It consumes that block's one-cycle `tick` strobe as its sampling clock-enable and filters a raw, asynchronous, bouncing input into a clean debounced level. It also produces one-cycle rise and fall strobes that later stages (counters, mode FSMs) use as single-event inputs.

---
 rtl/debounce_fsm_if.sv | 26 ++
 rtl/debounce_fsm.sv | 115 +++++++++++
 tb/tb_debounce_fsm.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/debounce_fsm_if.sv
// Signal bundle between the tick/switch source and the debouncer.
// The master drives the sampling strobe and the raw switch level.
// The slave (the debouncer) returns the clean level and the edge strobes.
interface debounce_fsm_if;
  logic tick;
  logic sw;
  logic db;
  logic db_rise;
  logic db_fall;

  modport master (
    output tick,
    output sw,
    input  db,
    input  db_rise,
    input  db_fall
  );

  modport slave (
    input  tick,
    input  sw,
    output db,
    output db_rise,
    output db_fall
  );
endinterface

// File: rtl/debounce_fsm.sv
// Tick-driven switch debouncer.
// The raw switch passes through a two-flop synchronizer. A four-state FSM
// then accepts a new level only after SAMPLES counted ticks of stable input.
// The tick that arrives on the same edge as entry into a WAIT state is not
// counted, so the accepted stable time is (SAMPLES-1)*P+1 .. SAMPLES*P cycles.
// All outputs are registered from next-state logic, so no input reaches an
// output combinationally.
module debounce_fsm #(
  parameter int unsigned SAMPLES = 3
) (
  input  logic           clk,
  input  logic           reset,
  debounce_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [7:0] LAST = 8'(SAMPLES - 1);

  logic       s1;
  logic       sw_s;
  state_t     state;
  state_t     next_state;
  logic [7:0] cnt;
  logic [7:0] next_cnt;
  logic       db_q;
  logic       rise_q;
  logic       fall_q;
  logic       next_db;
  logic       next_rise;
  logic       next_fall;

  // Two-flop synchronizer for the asynchronous switch input
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      sw_s <= 1'b0;
    end else begin
      s1   <= bus.sw;
      sw_s <= s1;
    end
  end

  // State, sample counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ZERO;
      cnt    <= 8'd0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= next_cnt;
      db_q   <= next_db;
      rise_q <= next_rise;
      fall_q <= next_fall;
    end
  end

  // Next-state and next-output logic; a bounce back always beats a tick
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ZERO: begin
        if (sw_s) begin
          next_state = WAIT1;
          next_cnt   = 8'd0;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          next_state = ZERO;
        end else if (bus.tick && (cnt == LAST)) begin
          next_state = ONE;
        end else if (bus.tick) begin
          next_cnt = cnt + 8'd1;
        end
      end
      ONE: begin
        if (!sw_s) begin
          next_state = WAIT0;
          next_cnt   = 8'd0;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          next_state = ONE;
        end else if (bus.tick && (cnt == LAST)) begin
          next_state = ZERO;
        end else if (bus.tick) begin
          next_cnt = cnt + 8'd1;
        end
      end
      default: begin
        next_state = ZERO;
        next_cnt   = 8'd0;
      end
    endcase
    next_db   = (next_state == ONE) || (next_state == WAIT0);
    next_rise = (state == WAIT1) && (next_state == ONE);
    next_fall = (state == WAIT0) && (next_state == ZERO);
  end

  assign bus.db      = db_q;
  assign bus.db_rise = rise_q;
  assign bus.db_fall = fall_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Self-checking bench for debounce_fsm.
// Directed scenarios followed by randomized switch/tick/reset traffic, all
// checked every cycle against a reference model that tracks "how many ticks
// has the synchronized input disagreed with the clean level".
module tb_debounce_fsm;
  localparam int SAMPLES = 3;

  logic clk = 1'b0;
  logic reset;

  debounce_fsm_if bus();

  debounce_fsm #(.SAMPLES(SAMPLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit m_s1, m_sws, m_db, m_rise, m_fall, m_wait;
  int m_ticks;

  int riseSeen, fallSeen, risePos, fallPos;

  task automatic checkOutput(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference model, given the inputs sampled there
  task automatic modelEdge(bit r, bit t, bit s);
    bit seen;
    if (r) begin
      m_s1 = 0; m_sws = 0; m_db = 0; m_rise = 0; m_fall = 0;
      m_wait = 0; m_ticks = 0;
    end else begin
      seen   = m_sws;
      m_sws  = m_s1;
      m_s1   = s;
      m_rise = 0;
      m_fall = 0;
      if (seen == m_db) begin
        m_wait = 0;
      end else if (!m_wait) begin
        m_wait  = 1;
        m_ticks = 0;
      end else if (t) begin
        m_ticks++;
        if (m_ticks == SAMPLES) begin
          m_db   = ~m_db;
          m_rise = m_db;
          m_fall = ~m_db;
          m_wait = 0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, compare all outputs
  task automatic applyStimulus(bit r, bit t, bit s);
    @(negedge clk);
    reset   = r;
    bus.tick = t;
    bus.sw   = s;
    @(posedge clk);
    modelEdge(r, t, s);
    #1;
    checkOutput("db", bus.db, m_db);
    checkOutput("db_rise", bus.db_rise, m_rise);
    checkOutput("db_fall", bus.db_fall, m_fall);
    if (bus.db_rise === 1'b1) riseSeen++;
    if (bus.db_fall === 1'b1) fallSeen++;
  endtask

  task automatic clearCounts();
    riseSeen = 0; fallSeen = 0; risePos = -1; fallPos = -1;
  endtask

  initial begin
    int segLen;
    bit level;
    reset    = 1'b1;
    bus.tick = 1'b0;
    bus.sw   = 1'b0;

    // Reset held with sw=1 and tick every cycle
    clearCounts();
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1);
    checkCount("reset_rise_count", riseSeen, 0);
    checkCount("reset_fall_count", fallSeen, 0);

    // Clean press, tick period 4: rise on the 3rd counted tick (cycle 11)
    clearCounts();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, (i % 4) == 3, 1);
      if (bus.db_rise === 1'b1) risePos = i;
    end
    checkCount("press_rise_count", riseSeen, 1);
    checkCount("press_rise_pos", risePos, 11);
    checkCount("press_fall_count", fallSeen, 0);
    checkOutput("press_db_final", bus.db, 1'b1);

    // Release, tick period 4: fall on the 3rd counted tick (cycle 11)
    clearCounts();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, (i % 4) == 3, 0);
      if (bus.db_fall === 1'b1) fallPos = i;
    end
    checkCount("release_fall_count", fallSeen, 1);
    checkCount("release_fall_pos", fallPos, 11);
    checkCount("release_rise_count", riseSeen, 0);

    // Bounce rejection: 3-cycle levels for 40 cycles, tick every cycle
    clearCounts();
    for (int i = 0; i < 40; i++) applyStimulus(0, 1, ((i / 3) % 2) == 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0);
    checkCount("bounce_rise_count", riseSeen, 0);
    checkCount("bounce_fall_count", fallSeen, 0);
    checkOutput("bounce_db", bus.db, 1'b0);

    // Bounce on the same edge as the 3rd tick in WAIT1
    clearCounts();
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0);
    checkCount("bounce_tick_rise_count", riseSeen, 0);
    checkOutput("bounce_tick_db", bus.db, 1'b0);

    // Reset while in WAIT0 with one tick counted, then re-debounce sw=1
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1);
    checkOutput("pre_wait0_db", bus.db, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(0, (i % 4) == 3, 0);
    applyStimulus(1, 0, 1);
    checkOutput("mid_reset_db", bus.db, 1'b0);
    clearCounts();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, (i % 4) == 3, 1);
      if (bus.db_rise === 1'b1) risePos = i;
    end
    checkCount("post_reset_rise_count", riseSeen, 1);
    checkCount("post_reset_rise_pos", risePos, 11);

    // Tick absent: sw wanders, db must never change
    clearCounts();
    for (int i = 0; i < 200; i++) applyStimulus(0, 0, $urandom_range(0, 1) == 1);
    checkCount("no_tick_rise_count", riseSeen, 0);
    checkCount("no_tick_fall_count", fallSeen, 0);
    checkOutput("no_tick_db", bus.db, 1'b1);

    // Randomized traffic: stable stretches, bouncy stretches, rare resets
    level = 1'b0;
    for (int seg = 0; seg < 150; seg++) begin
      segLen = $urandom_range(1, 30);
      level  = ~level;
      for (int i = 0; i < segLen; i++) begin
        bit s;
        s = (seg % 3 == 0) ? ($urandom_range(0, 1) == 1) : level;
        applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, s);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
